quadrature_mixer_accumulator: RTL and testbench

- Downstream consumer of the sin/cos DCO outputs.
- Multiplies each signed ADC sample by the DCO SIN_VALUE and COS_VALUE, and accumulates both products over a programmable window of N samples (integrate-and-dump).
- At the end of each window it presents the two sums with a one-cycle valid strobe.
- The sums are the I/Q correlation results used by the downstream phase/amplitude logic.

---
 rtl/quadrature_mixer_accumulator.sv | 112 +++++++++++
 tb/tb_quadrature_mixer_accumulator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_mixer_accumulator.sv
// Quadrature mixer with integrate-and-dump: multiplies ADC samples by the DCO sin/cos
// and presents the per-window I/Q correlation sums with a one-cycle valid strobe.
module quadrature_mixer_accumulator #(
  parameter int ADC_DATA_WIDTH       = 12,
  parameter int SIN_TABLE_DATA_WIDTH = 13,
  parameter int COUNTER_BITS         = 16,
  parameter int ACC_WIDTH            = 48
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   CE,
  input  logic signed [ADC_DATA_WIDTH-1:0]       ADC_VALUE,
  input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] SIN_VALUE,
  input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] COS_VALUE,
  input  logic        [COUNTER_BITS-1:0]         SAMPLE_COUNT,
  output logic signed [ACC_WIDTH-1:0]            SIN_SUM,
  output logic signed [ACC_WIDTH-1:0]            COS_SUM,
  output logic                                   SUM_VALID
);

  localparam int PROD_WIDTH = ADC_DATA_WIDTH + SIN_TABLE_DATA_WIDTH;

  typedef enum logic {FILL, ACCUM} state_t;

  state_t state, next_state;

  logic signed [ADC_DATA_WIDTH-1:0]       adc_q;
  logic signed [SIN_TABLE_DATA_WIDTH-1:0] sin_q, cos_q;
  logic                                   v1, v2;
  logic signed [PROD_WIDTH-1:0]           sin_prod, cos_prod;
  logic signed [ACC_WIDTH-1:0]            sin_acc, cos_acc;
  logic        [COUNTER_BITS-1:0]         remaining;
  logic                                   win_start;

  logic                          accumulate, start_edge, dump;
  logic        [COUNTER_BITS-1:0] window_len;
  logic signed [ACC_WIDTH-1:0]   sin_ext, cos_ext, sin_total, cos_total;

  // remaining counts the samples still owed to the open window after the current one,
  // so a length-1 window dumps on its own start edge.
  always_comb begin
    next_state = state;
    accumulate = CE && v2;
    start_edge = accumulate && (state == FILL || win_start);
    window_len = (SAMPLE_COUNT == '0) ? COUNTER_BITS'(1) : SAMPLE_COUNT;
    dump       = 1'b0;
    if (accumulate) begin
      if (start_edge) dump = (window_len == COUNTER_BITS'(1));
      else            dump = (remaining == COUNTER_BITS'(1));
    end
    sin_ext   = {{(ACC_WIDTH-PROD_WIDTH){sin_prod[PROD_WIDTH-1]}}, sin_prod};
    cos_ext   = {{(ACC_WIDTH-PROD_WIDTH){cos_prod[PROD_WIDTH-1]}}, cos_prod};
    sin_total = (start_edge ? '0 : sin_acc) + sin_ext;
    cos_total = (start_edge ? '0 : cos_acc) + cos_ext;
    if (state == FILL && accumulate) next_state = ACCUM;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= FILL;
    else       state <= next_state;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      adc_q    <= '0;
      sin_q    <= '0;
      cos_q    <= '0;
      v1       <= 1'b0;
      sin_prod <= '0;
      cos_prod <= '0;
      v2       <= 1'b0;
    end else if (CE) begin
      adc_q    <= ADC_VALUE;
      sin_q    <= SIN_VALUE;
      cos_q    <= COS_VALUE;
      v1       <= 1'b1;
      sin_prod <= PROD_WIDTH'(adc_q) * PROD_WIDTH'(sin_q);
      cos_prod <= PROD_WIDTH'(adc_q) * PROD_WIDTH'(cos_q);
      v2       <= v1;
    end
  end

  // SUM_VALID defaults low on every edge, so CE=0 edges also end the pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sin_acc   <= '0;
      cos_acc   <= '0;
      remaining <= '0;
      win_start <= 1'b0;
      SIN_SUM   <= '0;
      COS_SUM   <= '0;
      SUM_VALID <= 1'b0;
    end else begin
      SUM_VALID <= 1'b0;
      if (accumulate) begin
        if (dump) begin
          SIN_SUM   <= sin_total;
          COS_SUM   <= cos_total;
          SUM_VALID <= 1'b1;
          win_start <= 1'b1;
        end else begin
          sin_acc   <= sin_total;
          cos_acc   <= cos_total;
          win_start <= 1'b0;
          remaining <= start_edge ? window_len - COUNTER_BITS'(1)
                                  : remaining - COUNTER_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_quadrature_mixer_accumulator.sv
// Directed test of quadrature_mixer_accumulator: window sums, CE gating, N boundaries,
// ramp contiguity and mid-window reset, each checked with immediate assertions.
module tb_quadrature_mixer_accumulator;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               CE;
  logic signed [11:0] ADC_VALUE;
  logic signed [12:0] SIN_VALUE;
  logic signed [12:0] COS_VALUE;
  logic        [15:0] SAMPLE_COUNT;
  logic signed [47:0] SIN_SUM;
  logic signed [47:0] COS_SUM;
  logic               SUM_VALID;

  int total = 0;
  int bad   = 0;

  quadrature_mixer_accumulator dut (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .ADC_VALUE(ADC_VALUE), .SIN_VALUE(SIN_VALUE), .COS_VALUE(COS_VALUE),
    .SAMPLE_COUNT(SAMPLE_COUNT),
    .SIN_SUM(SIN_SUM), .COS_SUM(COS_SUM), .SUM_VALID(SUM_VALID)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic signed [11:0] adc, input logic signed [12:0] s,
                               input logic signed [12:0] c, input logic [15:0] n);
    ADC_VALUE    = adc;
    SIN_VALUE    = s;
    COS_VALUE    = c;
    SAMPLE_COUNT = n;
  endtask

  task automatic doReset();
    RESET = 1'b1;
    CE    = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  // Edges until SUM_VALID is seen high, or -1 if the bound expires.
  task automatic waitPulse(input int limit, output int edges);
    int  i;
    edges = -1;
    i     = 0;
    while (edges < 0 && i < limit) begin
      step();
      i++;
      if (SUM_VALID === 1'b1) edges = i;
    end
  endtask

  int     edges;
  int     ce_edges, pulse_at, pulses, zero_edge_valid;
  longint g_sin, g_cos;
  int     ramp_pulses;
  longint ramp_exp[3];

  initial begin
    RESET = 1'b0;
    CE    = 1'b0;
    applyStimulus(12'sd0, 13'sd0, 13'sd0, 16'd0);
    @(negedge CLK);

    // Reset state and basic N=4 sums.
    applyStimulus(12'sd100, 13'sd1000, -13'sd1000, 16'd4);
    doReset();
    checkOutput("reset_valid", longint'(SUM_VALID), 0);
    checkOutput("reset_sin", SIN_SUM, 0);
    checkOutput("reset_cos", COS_SUM, 0);
    waitPulse(20, edges);
    checkOutput("basic_first_edge", edges, 6);
    checkOutput("basic_sin", SIN_SUM, 400000);
    checkOutput("basic_cos", COS_SUM, -400000);
    step();
    checkOutput("basic_pulse_width", longint'(SUM_VALID), 0);
    checkOutput("basic_hold_sin", SIN_SUM, 400000);
    waitPulse(20, edges);
    checkOutput("basic_period", edges, 3);
    checkOutput("basic_sin2", SIN_SUM, 400000);
    checkOutput("basic_cos2", COS_SUM, -400000);

    // Extreme operands over the longest window.
    applyStimulus(-12'sd2048, -13'sd4096, 13'sd4095, 16'd65535);
    doReset();
    waitPulse(70000, edges);
    checkOutput("extreme_edge", edges, 65537);
    checkOutput("extreme_sin", SIN_SUM, longint'(65535) * longint'(-2048) * longint'(-4096));
    checkOutput("extreme_cos", COS_SUM, longint'(65535) * longint'(-2048) * longint'(4095));

    // CE toggling 1,0,1,0: pulse after the 6th enabled edge, cleared by the CE=0 edge.
    applyStimulus(12'sd100, 13'sd1000, -13'sd1000, 16'd4);
    doReset();
    ce_edges = 0; pulse_at = -1; pulses = 0; zero_edge_valid = 0;
    g_sin = 0; g_cos = 0;
    for (int k = 0; k < 8; k++) begin
      CE = 1'b1;
      step();
      ce_edges++;
      if (SUM_VALID === 1'b1) begin
        pulses++;
        if (pulse_at < 0) begin
          pulse_at = ce_edges;
          g_sin    = SIN_SUM;
          g_cos    = COS_SUM;
        end
      end
      CE = 1'b0;
      step();
      if (SUM_VALID !== 1'b0) zero_edge_valid++;
    end
    CE = 1'b1;
    checkOutput("gate_pulse_at", pulse_at, 6);
    checkOutput("gate_pulse_count", pulses, 1);
    checkOutput("gate_ce0_valid", zero_edge_valid, 0);
    checkOutput("gate_sin", g_sin, 400000);
    checkOutput("gate_cos", g_cos, -400000);

    // N=0 behaves as N=1: a dump every edge of a single product.
    applyStimulus(12'sd7, 13'sd3, -13'sd5, 16'd0);
    doReset();
    waitPulse(10, edges);
    checkOutput("n0_first_edge", edges, 3);
    checkOutput("n0_sin", SIN_SUM, 21);
    checkOutput("n0_cos", COS_SUM, -35);
    step();
    checkOutput("n0_every_edge", longint'(SUM_VALID), 1);
    applyStimulus(12'sd11, 13'sd3, -13'sd5, 16'd1);
    step();
    checkOutput("n1_valid_a", longint'(SUM_VALID), 1);
    checkOutput("n1_sin_a", SIN_SUM, 21);
    step();
    checkOutput("n1_valid_b", longint'(SUM_VALID), 1);
    step();
    checkOutput("n1_valid_c", longint'(SUM_VALID), 1);
    checkOutput("n1_sin_c", SIN_SUM, 33);
    checkOutput("n1_cos_c", COS_SUM, -55);

    // N changed 3 -> 5 mid-window: takes effect on the following window.
    applyStimulus(12'sd1, 13'sd1, 13'sd1, 16'd3);
    doReset();
    waitPulse(20, edges);
    checkOutput("nchg_first_edge", edges, 5);
    checkOutput("nchg_first_sin", SIN_SUM, 3);
    step();
    SAMPLE_COUNT = 16'd5;
    waitPulse(20, edges);
    checkOutput("nchg_old_window_edges", edges, 2);
    checkOutput("nchg_old_window_sin", SIN_SUM, 3);
    waitPulse(20, edges);
    checkOutput("nchg_new_window_edges", edges, 5);
    checkOutput("nchg_new_window_sin", SIN_SUM, 5);

    // Ramp 1,2,3,... with N=3 gives contiguous windows 6, 15, 24.
    applyStimulus(12'sd1, 13'sd1, 13'sd0, 16'd3);
    doReset();
    ramp_exp[0] = 6; ramp_exp[1] = 15; ramp_exp[2] = 24;
    ramp_pulses = 0;
    for (int k = 0; k < 11; k++) begin
      step();
      ADC_VALUE = ADC_VALUE + 12'sd1;
      if (SUM_VALID === 1'b1) begin
        if (ramp_pulses < 3) checkOutput($sformatf("ramp_sum%0d", ramp_pulses), SIN_SUM, ramp_exp[ramp_pulses]);
        ramp_pulses++;
      end
    end
    checkOutput("ramp_pulse_count", ramp_pulses, 3);

    // Reset after 5 samples of an N=8 window discards the partial sum.
    applyStimulus(12'sd3, 13'sd2, -13'sd1, 16'd8);
    doReset();
    waitPulse(30, edges);
    checkOutput("rst_first_edge", edges, 10);
    checkOutput("rst_first_sin", SIN_SUM, 48);
    checkOutput("rst_first_cos", COS_SUM, -24);
    for (int k = 0; k < 5; k++) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checkOutput("rst_mid_sin", SIN_SUM, 0);
    checkOutput("rst_mid_cos", COS_SUM, 0);
    checkOutput("rst_mid_valid", longint'(SUM_VALID), 0);
    waitPulse(30, edges);
    checkOutput("rst_release_edge", edges, 10);
    checkOutput("rst_release_sin", SIN_SUM, 48);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
